// File: rtl/snitch_icache_data_arbiter.sv
// snitch_icache_data_arbiter
//
// Purpose:
//   Arbitrates the single read/write port of the icache data SRAM between
//   the lookup read path and the refill write path. It forms the flat SRAM
//   address {way, line}, turns the 1-cycle SRAM read latency into a
//   valid/ready response stream, and limits how many writes may pass a
//   waiting read in a row.
//
// Handshake semantics (applies to every valid/ready pair on this block):
//   A transfer happens in a cycle where valid and ready are both high.
//   A valid must not depend on its ready. Once rd_rsp_valid_o is raised, it
//   and rd_rsp_data_o stay stable until the transfer happens.
//   rd_req_ready_o and wr_req_ready_o are the SRAM grants themselves, so they
//   are combinational from the request valids.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   rd_req_*                  lookup read request (way, line)
//   rd_rsp_*                  read response stream
//   wr_req_*                  refill write request (way, line, data)
//   sram_*                    SRAM port, address = {way, line}
//   dbg_state_o               current sequencer state (IDLE/RD_DATA/RSP_HOLD)
//   perf_conflict_o           (SNITCH_ICACHE_DATA_ARB_PERF_EN only) cycles with
//                             both a read and a write eligible
//   perf_rsp_stall_o          (SNITCH_ICACHE_DATA_ARB_PERF_EN only) cycles with
//                             a response offered but not accepted
//
// Optional feature macro: SNITCH_ICACHE_DATA_ARB_PERF_EN
module snitch_icache_data_arbiter #(
    parameter int unsigned LINE_WIDTH       = 128,
    parameter int unsigned LINE_COUNT       = 64,
    parameter int unsigned WAY_COUNT        = 4,
    parameter int unsigned WRITE_STREAK_MAX = 4,
    localparam int unsigned IDX_W           = $clog2(LINE_COUNT),
    localparam int unsigned WAY_W           = $clog2(WAY_COUNT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rd_req_valid_i,
    output logic                   rd_req_ready_o,
    input  logic [WAY_W-1:0]       rd_way_i,
    input  logic [IDX_W-1:0]       rd_line_i,
    output logic                   rd_rsp_valid_o,
    input  logic                   rd_rsp_ready_i,
    output logic [LINE_WIDTH-1:0]  rd_rsp_data_o,
    input  logic                   wr_req_valid_i,
    output logic                   wr_req_ready_o,
    input  logic [WAY_W-1:0]       wr_way_i,
    input  logic [IDX_W-1:0]       wr_line_i,
    input  logic [LINE_WIDTH-1:0]  wr_data_i,
    output logic                   sram_req_o,
    output logic                   sram_write_o,
    output logic [WAY_W+IDX_W-1:0] sram_addr_o,
    output logic [LINE_WIDTH-1:0]  sram_wdata_o,
    input  logic [LINE_WIDTH-1:0]  sram_rdata_i,
    output logic [1:0]             dbg_state_o
`ifdef SNITCH_ICACHE_DATA_ARB_PERF_EN
    ,
    output logic [31:0]            perf_conflict_o,
    output logic [31:0]            perf_rsp_stall_o
`endif
);

    localparam int unsigned STREAK_W = $clog2(WRITE_STREAK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DATA  = 2'd1,
        RSP_HOLD = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [LINE_WIDTH-1:0] hold_q, hold_d;

    logic rsp_accept;
    logic rsp_free;
    logic rd_elig;
    logic wr_elig;
    logic streak_full;
    logic rd_grant;
    logic wr_grant;

    assign rd_rsp_valid_o = (state_q != IDLE);
    assign dbg_state_o    = state_q;

    always_comb begin
        rsp_accept  = rd_rsp_valid_o & rd_rsp_ready_i;
        // A new read may issue in the same cycle the old response leaves.
        rsp_free    = (state_q == IDLE) | rsp_accept;
        rd_elig     = rd_req_valid_i & rsp_free;
        wr_elig     = wr_req_valid_i;
        streak_full = (streak_q == STREAK_W'(WRITE_STREAK_MAX));
        // Grants are blocked while in reset so a refill write cannot land.
        rd_grant    = ~rst_i & rd_elig & (~wr_elig | streak_full);
        wr_grant    = ~rst_i & wr_elig & ~rd_grant;
    end

    always_comb begin
        rd_req_ready_o = rd_grant;
        wr_req_ready_o = wr_grant;
        sram_req_o     = rd_grant | wr_grant;
        sram_write_o   = wr_grant;
        sram_wdata_o   = wr_grant ? wr_data_i : '0;
        sram_addr_o    = '0;
        if (rd_grant) begin
            sram_addr_o = {rd_way_i, rd_line_i};
        end else if (wr_grant) begin
            sram_addr_o = {wr_way_i, wr_line_i};
        end
    end

    always_comb begin
        rd_rsp_data_o = '0;
        case (state_q)
            RD_DATA:  rd_rsp_data_o = sram_rdata_i;
            RSP_HOLD: rd_rsp_data_o = hold_q;
            default:  rd_rsp_data_o = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        streak_d = streak_q;

        // The streak only measures writes that overtook a waiting read.
        if (rd_grant || !rd_elig) begin
            streak_d = '0;
        end else if (wr_grant && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rd_grant) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rd_rsp_ready_i) begin
                    state_d = rd_grant ? RD_DATA : IDLE;
                end else begin
                    // SRAM data is only valid for one cycle; keep a copy.
                    hold_d  = sram_rdata_i;
                    state_d = RSP_HOLD;
                end
            end
            RSP_HOLD: begin
                if (rd_rsp_ready_i) state_d = rd_grant ? RD_DATA : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst_i) begin
            state_d  = IDLE;
            hold_d   = '0;
            streak_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q  <= state_d;
        hold_q   <= hold_d;
        streak_q <= streak_d;
    end

`ifdef SNITCH_ICACHE_DATA_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_rsp_stall_q, perf_rsp_stall_d;

    always_comb begin
        perf_conflict_d  = perf_conflict_q + {31'd0, (rd_elig & wr_elig)};
        perf_rsp_stall_d = perf_rsp_stall_q + {31'd0, (rd_rsp_valid_o & ~rd_rsp_ready_i)};
        if (rst_i) begin
            perf_conflict_d  = '0;
            perf_rsp_stall_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        perf_conflict_q  <= perf_conflict_d;
        perf_rsp_stall_q <= perf_rsp_stall_d;
    end

    assign perf_conflict_o  = perf_conflict_q;
    assign perf_rsp_stall_o = perf_rsp_stall_q;
`endif

endmodule

// File: doc/snitch_icache_data_arbiter.md
Name: snitch_icache_data_arbiter

Overview:
- Single-port arbiter and sequencer in front of the serial icache data SRAM (LINE_COUNT*WAY_COUNT words of LINE_WIDTH, 1R/W port, 1-cycle read latency).
- Shares the SRAM between the lookup read path and the refill write path.
- Forms the flat SRAM address {way, line}, registers the read response and applies back-pressure.
- Bounds write priority so lookups cannot starve during long refill bursts.

Parameters:
- LINE_WIDTH, 128, data line width in bits.
- LINE_COUNT, 64, lines per way; power of two; IDX_W = $clog2(LINE_COUNT).
- WAY_COUNT, 4, ways; power of two >= 2; WAY_W = $clog2(WAY_COUNT).
- WRITE_STREAK_MAX, 4, consecutive write grants allowed while a read waits (>= 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- rd_req_valid_i  in  1  lookup read request valid.
- rd_req_ready_o  out  1  read request accepted (granted to SRAM this cycle).
- rd_way_i  in  WAY_W  read way.
- rd_line_i  in  IDX_W  read line index.
- rd_rsp_valid_o  out  1  read data valid.
- rd_rsp_ready_i  in  1  consumer accepts read data.
- rd_rsp_data_o  out  LINE_WIDTH  read data.
- wr_req_valid_i  in  1  refill write valid.
- wr_req_ready_o  out  1  write accepted (performed this cycle).
- wr_way_i  in  WAY_W  write way.
- wr_line_i  in  IDX_W  write line index.
- wr_data_i  in  LINE_WIDTH  write data.
- sram_req_o  out  1  SRAM request.
- sram_write_o  out  1  SRAM write enable.
- sram_addr_o  out  WAY_W+IDX_W  SRAM address = {way, line}; way in the MSBs.
- sram_wdata_o  out  LINE_WIDTH  SRAM write data.
- sram_rdata_i  in  LINE_WIDTH  SRAM read data; valid the cycle after a read request.

Behaviour:
- Reset: all outputs 0; state IDLE; streak counter 0; hold register cleared.
- Grant rule: SRAM carries at most one access per cycle.
  - Read eligible iff rd_req_valid_i and rsp_free.
  - rsp_free = no response pending, or the pending response is being accepted this cycle (rd_rsp_valid_o & rd_rsp_ready_i).
  - Write wins when both are eligible, unless streak == WRITE_STREAK_MAX; then the read wins.
- Streak counter:
  - +1 on each write grant while a read is eligible-but-not-granted.
  - Reset to 0 on any read grant, or on any cycle where no read is eligible.
  - Saturates at WRITE_STREAK_MAX.
- Ready outputs: rd_req_ready_o / wr_req_ready_o = the grant. Combinational from valids; valids must not depend on readies.
- Outputs on a grant: sram_req_o=1; sram_write_o=1 only for a write; sram_wdata_o = wr_data_i on writes, 0 otherwise; sram_addr_o from the granted requester.
- States:
  - IDLE: no read outstanding.
  - RD_DATA: read issued last cycle. rd_rsp_valid_o=1 and rd_rsp_data_o = sram_rdata_i (pass-through).
    - Accepted and new read granted -> stay RD_DATA.
    - Accepted, no new read -> IDLE.
    - Not accepted -> capture sram_rdata_i into the hold register -> RSP_HOLD.
  - RSP_HOLD: rd_rsp_valid_o=1, data from the hold register, stable until accepted. Writes may still be granted; reads are not, except in the cycle of acceptance.
    - Accepted with a read grant -> RD_DATA; accepted without one -> IDLE.
- Latency and throughput: read response 1 cycle after grant; sustained 1 read/cycle with rd_rsp_ready_i high; writes 1/cycle.
- Ordering: no forwarding. A read granted after a write to the same address returns the new data. A read granted before it returns the old data, even while held in RSP_HOLD.
- Reset mid-operation: any pending or held response is dropped (rd_rsp_valid_o=0 next cycle). An SRAM write granted in the reset cycle is suppressed: sram_req_o=0 while rst_i=1.

Optional Feature:
- Macro: SNITCH_ICACHE_DATA_ARB_PERF_EN.
- Defined: adds outputs perf_conflict_o (32) and perf_rsp_stall_o (32).
  - perf_conflict_o counts cycles with both a read and a write eligible.
  - perf_rsp_stall_o counts cycles with rd_rsp_valid_o=1 and rd_rsp_ready_i=0.
  - Both wrap at 2^32 and are cleared by rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single read, way=2, line=5, rsp_ready=1 -> sram_addr_o=0x85 (WAY_W=2, IDX_W=6), sram_write_o=0; one cycle later rd_rsp_valid_o=1 with the SRAM word.
- 8 back-to-back reads, rsp_ready=1 -> 8 consecutive grants, 8 responses on consecutive cycles, no bubbles.
- Read, then rsp_ready low for 3 cycles while a write to a different address arrives -> write granted during the hold; rd_rsp_data_o stable for all 3 cycles; no new read granted until acceptance.
- Continuous writes plus a continuous read, WRITE_STREAK_MAX=4 -> grant pattern W,W,W,W,R repeating.
- Write A=0xDEAD…, then read A next cycle -> read returns 0xDEAD…; a read of A granted before the write returns the old value.
- Assert rst_i while in RSP_HOLD -> rd_rsp_valid_o=0 the following cycle, state IDLE; with PERF_EN, both counters read 0.
